ysyx_23060072_bpu_resolve: RTL and testbench
============================================

Name: ysyx_23060072_bpu_resolve

Overview:
- EX-stage counterpart of the IF-stage static branch predictor.
- Holds every prediction IF makes for JAL/branch instructions in a small in-order queue.
- Checks each queued prediction against the actual outcome computed in EX. On a mismatch it flushes the pipeline and returns a registered redirect PC to IF over a valid/ready handshake.
- Also keeps branch and mispredict performance counters.

Parameters:
- DEPTH, 4, prediction queue entries; power of two, minimum 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pred_push_i  in  1  IF pushes one prediction record; asserted only for JAL/branch
- pred_pc_i  in  32  instruction address
- pred_flag_i  in  1  predicted taken
- pred_target_i  in  32  predicted next PC when taken
- pred_full_o  out  1  queue full; IF must stall further JAL/branch fetches
- resolve_valid_i  in  1  EX resolves the oldest JAL/branch
- resolve_taken_i  in  1  actual taken
- resolve_target_i  in  32  actual target when taken
- flush_o  out  1  one-cycle pulse, kills IF/ID/EX younger instructions
- redirect_valid_o  out  1  corrected PC available
- redirect_pc_o  out  32  corrected PC
- redirect_ready_i  in  1  IF accepts redirect
- resolve_err_o  out  1  one-cycle pulse, resolve with empty queue
- branch_cnt_o  out  CNT_W  resolved JAL/branch count
- mispred_cnt_o  out  CNT_W  mispredict count

Behaviour:
- Reset (clk edge with rst=1): queue empty, read and write pointers 0, pending cleared, all outputs 0, counters 0. Reset overrides everything, including a pending redirect.
- Queue:
  - Circular buffer with DEPTH entries.
  - An extra pointer bit distinguishes full from empty.
  - pred_full_o = occupancy==DEPTH, combinational from pointers.
- Push acceptance: a push is accepted when not full, or when full but a pop happens in the same cycle.
  - A push while full with no pop is dropped. The count does not change; a protocol violation that the bench flags.
- Resolve (resolve_valid_i=1, queue not empty, no pending redirect):
  - Pop the head entry {pc, flag, target}.
  - actual_pc = resolve_taken_i ? resolve_target_i : pc+32'd4 (mod 2^32).
  - mispredict = (flag != resolve_taken_i) | (resolve_taken_i & (target != resolve_target_i)).
  - branch_cnt increments by 1, saturating at all-ones.
- Mispredict:
  - Next cycle: flush_o=1 for one cycle, redirect_valid_o=1, redirect_pc_o=actual_pc, mispred_cnt increments by 1 (saturating).
  - Queue is cleared (all entries are wrong-path).
  - A push in the same cycle as the mispredicting resolve is discarded.
- Pending redirect:
  - redirect_valid_o stays 1 and redirect_pc_o stays stable until a cycle with redirect_ready_i=1, then both clear the following cycle.
  - While pending, all pushes and resolves are ignored: counters unchanged, no resolve_err_o.
- Correct prediction: the pop only; no flush, no redirect.
- Resolve with empty queue and no pending redirect: resolve_err_o=1 next cycle for one cycle; nothing else changes.
- Latency: resolve to flush/redirect is 1 cycle. Push to resolvable is 1 cycle (an entry pushed in cycle N may be resolved in cycle N+1).
- All outputs are registered except pred_full_o.

Test Plan:
- After reset: push {pc=0x80000000, flag=1, target=0x7FFFFFF0}; resolve taken with target 0x7FFFFFF0 -> no flush, branch_cnt=1, mispred_cnt=0, queue empty.
- Push {0x80000010, flag=0, 0x80000100}; resolve taken with target 0x80000100 -> next cycle flush_o pulses 1 cycle, redirect_pc_o=0x80000100; hold redirect_ready_i=0 for 3 cycles -> valid and PC held; ready=1 -> valid clears next cycle, mispred_cnt=1.
- Push {0x80000020, flag=1, 0x80000000}; resolve not taken -> redirect_pc_o=0x80000024.
- Push 4 entries -> pred_full_o=1; 5th push alone dropped; push plus resolve in the same cycle while full -> accepted, occupancy stays 4. Mispredict on the head -> queue empty, pred_full_o=0.
- Resolve with empty queue -> resolve_err_o single pulse, counters unchanged; resolve during pending redirect -> ignored.
- Push {0xFFFFFFFC, flag=1, X}; resolve not taken -> redirect_pc_o=0x00000000 (wrap). Assert rst while a redirect is pending -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ysyx_23060072_bpu_resolve.sv
// ysyx_23060072_bpu_resolve
//   EX-stage checker for the IF-stage static branch predictor. IF pushes one
//   record {pc, predicted-taken, predicted-target} per JAL/branch into a small
//   in-order queue. EX resolves the oldest record. On a mispredict the block
//   pulses a flush, drops the whole queue and hands the corrected PC back to
//   IF over a valid/ready handshake. It also counts resolved branches and
//   mispredicts.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   pred_push_i        IF pushes a prediction record (JAL/branch only)
//   pred_pc_i          instruction address of the record
//   pred_flag_i        predicted taken
//   pred_target_i      predicted next PC when taken
//   pred_full_o        queue full (combinational), IF must stall branches
//   resolve_valid_i    EX resolves the oldest queued branch
//   resolve_taken_i    actual taken
//   resolve_target_i   actual target when taken
//   flush_o            one-cycle pulse, kill younger instructions
//   redirect_valid_o   corrected PC available
//   redirect_pc_o      corrected PC
//   redirect_ready_i   IF accepts the redirect
//   resolve_err_o      one-cycle pulse, resolve seen with an empty queue
//   branch_cnt_o       resolved JAL/branch count (saturating)
//   mispred_cnt_o      mispredict count (saturating)
module ysyx_23060072_bpu_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_push_i,
    input  logic [31:0]      pred_pc_i,
    input  logic             pred_flag_i,
    input  logic [31:0]      pred_target_i,
    output logic             pred_full_o,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             resolve_err_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Queue storage (data only, never reset) and pointers with a wrap bit.
    logic [31:0] r_q_pc  [DEPTH];
    logic        r_q_flag[DEPTH];
    logic [31:0] r_q_tgt [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic             r_flush;
    logic             r_redir_valid;
    logic [31:0]      r_redir_pc;
    logic             r_err;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic        w_empty;
    logic        w_full;
    logic        w_resolve;
    logic        w_mispred;
    logic        w_push_ok;
    logic [31:0] w_head_pc;
    logic        w_head_flag;
    logic [31:0] w_head_tgt;
    logic [31:0] w_actual_pc;

    assign w_empty = (r_wptr == r_rptr);
    // Same slot index but different lap means the writer is a full lap ahead.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_head_pc   = r_q_pc  [r_rptr[AW-1:0]];
    assign w_head_flag = r_q_flag[r_rptr[AW-1:0]];
    assign w_head_tgt  = r_q_tgt [r_rptr[AW-1:0]];

    // A pending redirect freezes the queue: nothing resolves or pushes.
    assign w_resolve   = resolve_valid_i && !w_empty && !r_redir_valid;
    assign w_actual_pc = resolve_taken_i ? resolve_target_i : w_head_pc + 32'd4;
    assign w_mispred   = (w_head_flag != resolve_taken_i) ||
                         (resolve_taken_i && (w_head_tgt != resolve_target_i));

    // When full, a simultaneous pop frees the head slot the push lands in;
    // the head is read combinationally before the write takes effect.
    // A push alongside a mispredict is wrong-path and is discarded.
    assign w_push_ok = pred_push_i && !r_redir_valid &&
                       (!w_full || w_resolve) &&
                       !(w_resolve && w_mispred);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_pc  [r_wptr[AW-1:0]] <= pred_pc_i;
            r_q_flag[r_wptr[AW-1:0]] <= pred_flag_i;
            r_q_tgt [r_wptr[AW-1:0]] <= pred_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_flush       <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_err         <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush <= 1'b0;
            r_err   <= resolve_valid_i && w_empty && !r_redir_valid;

            if (r_redir_valid) begin
                if (redirect_ready_i) begin
                    r_redir_valid <= 1'b0;
                    r_redir_pc    <= '0;
                end
            end else if (w_resolve && w_mispred) begin
                // Everything still queued is younger and wrong-path: drop it.
                r_rptr        <= r_wptr;
                r_flush       <= 1'b1;
                r_redir_valid <= 1'b1;
                r_redir_pc    <= w_actual_pc;
                r_branch_cnt  <= sat_inc(r_branch_cnt);
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end else begin
                if (w_resolve) begin
                    r_rptr       <= r_rptr + PTR_ONE;
                    r_branch_cnt <= sat_inc(r_branch_cnt);
                end
                if (w_push_ok) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
            end
        end
    end

    assign pred_full_o      = w_full;
    assign flush_o          = r_flush;
    assign redirect_valid_o = r_redir_valid;
    assign redirect_pc_o    = r_redir_pc;
    assign resolve_err_o    = r_err;
    assign branch_cnt_o     = r_branch_cnt;
    assign mispred_cnt_o    = r_mispred_cnt;

endmodule

// File: tb/tb_ysyx_23060072_bpu_resolve.sv
module tb_ysyx_23060072_bpu_resolve;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_push_i;
    logic [31:0]      pred_pc_i;
    logic             pred_flag_i;
    logic [31:0]      pred_target_i;
    logic             pred_full_o;
    logic             resolve_valid_i;
    logic             resolve_taken_i;
    logic [31:0]      resolve_target_i;
    logic             flush_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             redirect_ready_i;
    logic             resolve_err_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    ysyx_23060072_bpu_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_push_i      (pred_push_i),
        .pred_pc_i        (pred_pc_i),
        .pred_flag_i      (pred_flag_i),
        .pred_target_i    (pred_target_i),
        .pred_full_o      (pred_full_o),
        .resolve_valid_i  (resolve_valid_i),
        .resolve_taken_i  (resolve_taken_i),
        .resolve_target_i (resolve_target_i),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .resolve_err_o    (resolve_err_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of prediction records plus expected outputs.
    typedef struct {
        logic [31:0] pc;
        logic        flag;
        logic [31:0] tgt;
    } ent_t;

    ent_t        m_q[$];
    logic        m_pend;
    logic [31:0] m_rpc;
    logic        m_flush;
    logic        m_err;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        ent_t        h;
        logic [31:0] actual;
        logic        mp;
        logic        res;
        m_flush = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_q.delete();
            m_pend = 1'b0;
            m_rpc  = 32'd0;
            m_bcnt = 32'd0;
            m_mcnt = 32'd0;
        end else if (m_pend) begin
            if (redirect_ready_i) begin
                m_pend = 1'b0;
                m_rpc  = 32'd0;
            end
        end else begin
            res = resolve_valid_i && (m_q.size() > 0);
            mp  = 1'b0;
            if (resolve_valid_i && m_q.size() == 0) m_err = 1'b1;
            if (res) begin
                h      = m_q.pop_front();
                actual = resolve_taken_i ? resolve_target_i : h.pc + 32'd4;
                mp     = (h.flag != resolve_taken_i) ||
                         (resolve_taken_i && h.tgt != resolve_target_i);
                m_bcnt = sat32(m_bcnt);
                if (mp) begin
                    m_q.delete();
                    m_pend  = 1'b1;
                    m_rpc   = actual;
                    m_flush = 1'b1;
                    m_mcnt  = sat32(m_mcnt);
                end
            end
            if (pred_push_i && !mp && m_q.size() < DEPTH) begin
                h.pc   = pred_pc_i;
                h.flag = pred_flag_i;
                h.tgt  = pred_target_i;
                m_q.push_back(h);
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("full",     {31'd0, pred_full_o},      {31'd0, (m_q.size() == DEPTH)});
        check_eq("flush",    {31'd0, flush_o},          {31'd0, m_flush});
        check_eq("rvalid",   {31'd0, redirect_valid_o}, {31'd0, m_pend});
        check_eq("rpc",      redirect_pc_o,             m_rpc);
        check_eq("err",      {31'd0, resolve_err_o},    {31'd0, m_err});
        check_eq("bcnt",     branch_cnt_o,              m_bcnt);
        check_eq("mcnt",     mispred_cnt_o,             m_mcnt);
    endtask

    task automatic idle();
        rst              = 1'b0;
        pred_push_i      = 1'b0;
        pred_pc_i        = 32'd0;
        pred_flag_i      = 1'b0;
        pred_target_i    = 32'd0;
        resolve_valid_i  = 1'b0;
        resolve_taken_i  = 1'b0;
        resolve_target_i = 32'd0;
        redirect_ready_i = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic fl, input logic [31:0] tg);
        pred_push_i   = 1'b1;
        pred_pc_i     = pc;
        pred_flag_i   = fl;
        pred_target_i = tg;
    endtask

    task automatic set_res(input logic tk, input logic [31:0] tg);
        resolve_valid_i  = 1'b1;
        resolve_taken_i  = tk;
        resolve_target_i = tg;
    endtask

    initial begin
        idle();
        m_pend = 1'b0; m_rpc = '0; m_bcnt = '0; m_mcnt = '0;
        #1;
        rst = 1'b1; step(); step();
        idle();

        // Correct taken prediction
        set_push(32'h8000_0000, 1'b1, 32'h7FFF_FFF0); step(); idle();
        set_res(1'b1, 32'h7FFF_FFF0); step(); idle();
        check_eq("tp1_bcnt", branch_cnt_o, 32'd1);
        check_eq("tp1_flush", {31'd0, flush_o}, 32'd0);

        // Predicted not taken, actually taken; redirect held while not ready
        set_push(32'h8000_0010, 1'b0, 32'h8000_0100); step(); idle();
        set_res(1'b1, 32'h8000_0100); step(); idle();
        check_eq("tp2_flush", {31'd0, flush_o}, 32'd1);
        check_eq("tp2_pc", redirect_pc_o, 32'h8000_0100);
        for (int i = 0; i < 3; i++) step();
        check_eq("tp2_hold_v", {31'd0, redirect_valid_o}, 32'd1);
        check_eq("tp2_hold_pc", redirect_pc_o, 32'h8000_0100);
        redirect_ready_i = 1'b1; step(); idle();
        check_eq("tp2_clear", {31'd0, redirect_valid_o}, 32'd0);
        check_eq("tp2_mcnt", mispred_cnt_o, 32'd1);

        // Predicted taken, actually not taken
        set_push(32'h8000_0020, 1'b1, 32'h8000_0000); step(); idle();
        set_res(1'b0, 32'd0); step(); idle();
        check_eq("tp3_pc", redirect_pc_o, 32'h8000_0024);
        redirect_ready_i = 1'b1; step(); idle();

        // Fill, overflow drop, push+pop while full, mispredict clears
        for (int i = 0; i < 4; i++) begin
            set_push(32'h9000_0000 + 32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i)); step(); idle();
        end
        check_eq("tp4_full", {31'd0, pred_full_o}, 32'd1);
        set_push(32'h9000_0100, 1'b1, 32'hB000_0000); step(); idle();
        set_push(32'h9000_0200, 1'b0, 32'hC000_0000);
        set_res(1'b1, 32'hA000_0000); step(); idle();
        check_eq("tp4_full2", {31'd0, pred_full_o}, 32'd1);
        set_res(1'b0, 32'd0); step(); idle();
        check_eq("tp4_empty", {31'd0, pred_full_o}, 32'd0);
        check_eq("tp4_pc", redirect_pc_o, 32'h9000_0008);
        redirect_ready_i = 1'b1; step(); idle();

        // Empty resolve error, then resolve during a pending redirect
        set_res(1'b1, 32'h1234_0000); step(); idle();
        check_eq("tp5_err", {31'd0, resolve_err_o}, 32'd1);
        step();
        check_eq("tp5_err_pulse", {31'd0, resolve_err_o}, 32'd0);
        set_push(32'h8000_0040, 1'b0, 32'h0); step(); idle();
        set_res(1'b1, 32'h8000_0400); step(); idle();
        set_push(32'h8000_0050, 1'b1, 32'h8); set_res(1'b1, 32'h8); step(); idle();
        set_res(1'b0, 32'h0); step(); idle();
        redirect_ready_i = 1'b1; step(); idle();

        // PC wrap, then reset while a redirect is pending
        set_push(32'hFFFF_FFFC, 1'b1, 32'h1234_5678); step(); idle();
        set_res(1'b0, 32'd0); step(); idle();
        check_eq("tp6_valid", {31'd0, redirect_valid_o}, 32'd1);
        check_eq("tp6_wrap", redirect_pc_o, 32'h0000_0000);
        rst = 1'b1; step(); idle();
        check_eq("tp6_rst_bcnt", branch_cnt_o, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_push($urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                         $urandom() & 32'hFFFF_FFFC);
            end
            if ($urandom_range(0, 2) != 0) begin
                if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    resolve_valid_i  = 1'b1;
                    resolve_taken_i  = ($urandom_range(0, 4) == 0) ? !m_q[0].flag : m_q[0].flag;
                    resolve_target_i = ($urandom_range(0, 4) == 0) ? $urandom() : m_q[0].tgt;
                end else begin
                    set_res(1'($urandom_range(0, 1)), $urandom());
                end
            end
            redirect_ready_i = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
